// File: rtl/dt_ctrl_pkg.sv
// Shared types, default widths and helpers for the decision-tree inference sequencer.
package dt_ctrl_pkg;

  localparam int DT_N_FEAT  = 16;
  localparam int DT_FEAT_W  = 10;
  localparam int DT_KEY_W   = 21;
  localparam int DT_N_CLASS = 5;

  typedef enum logic [1:0] {
    S_KEY  = 2'd0,
    S_IDLE = 2'd1,
    S_EVAL = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [DT_N_CLASS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < DT_N_CLASS; i++) begin
      n += 32'(v[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/dt_key_shreg.sv
// Serial unlock-key register: LSB-first shift-in, bit counter and loaded flag with synchronous wipe.
module dt_key_shreg
  import dt_ctrl_pkg::*;
#(
  parameter int KEY_W = DT_KEY_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clr,
  output logic [KEY_W-1:0] key,
  output logic             loaded
);

  localparam int CW = $clog2(KEY_W + 1);

  logic [KEY_W-1:0] r_key;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_loaded;

  // Once loaded, further shifts are ignored so the key cannot be disturbed.
  always_ff @(posedge CLK) begin
    if (!RST || clr) begin
      r_key     <= '0;
      r_bit_cnt <= '0;
      r_loaded  <= 1'b0;
    end else if (shift_en && !r_loaded) begin
      r_key     <= {bit_in, r_key[KEY_W-1:1]};
      r_bit_cnt <= r_bit_cnt + 1'b1;
      if (r_bit_cnt == CW'(KEY_W - 1)) begin
        r_loaded <= 1'b1;
      end
    end
  end

  assign key    = r_key;
  assign loaded = r_loaded;

endmodule

// File: rtl/dt_infer_ctrl.sv
// Inference sequencer around the combinational key-locked decision-tree core:
// key load, feature handshake, settle wait, decision capture and result handshake.
module dt_infer_ctrl
  import dt_ctrl_pkg::*;
#(
  parameter int N_FEAT  = DT_N_FEAT,
  parameter int FEAT_W  = DT_FEAT_W,
  parameter int KEY_W   = DT_KEY_W,
  parameter int N_CLASS = DT_N_CLASS,
  parameter int SETTLE  = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     key_shift_en,
  input  logic                     key_bit,
  input  logic                     key_clr,
  output logic                     key_loaded,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feats,
  output logic [N_FEAT*FEAT_W-1:0] core_feats,
  output logic [KEY_W-1:0]         core_key,
  input  logic [N_CLASS-1:0]       core_decision,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CLASS-1:0]       out_decision,
  output logic                     out_onehot_err,
  output logic [CNT_W-1:0]         infer_cnt
);

  localparam int SET_W = $clog2(SETTLE + 1);

  state_t                     r_state;
  state_t                     w_state;
  state_t                     w_state_next;
  logic                       w_in_ready;
  logic                       w_accept;
  logic                       w_capture;
  logic                       w_release;
  logic                       w_shift;
  logic [KEY_W-1:0]           w_key;
  logic                       w_key_loaded;
  logic [SET_W-1:0]           r_settle_cnt;
  logic [N_FEAT*FEAT_W-1:0]   r_core_feats;
  logic                       r_out_valid;
  logic [N_CLASS-1:0]         r_out_decision;
  logic                       r_out_onehot_err;
  logic [CNT_W-1:0]           r_infer_cnt;

  assign w_shift = key_shift_en && (w_state == S_KEY);

  dt_key_shreg #(
    .KEY_W (KEY_W)
  ) u_key (
    .CLK      (CLK),
    .RST      (RST),
    .shift_en (w_shift),
    .bit_in   (key_bit),
    .clr      (key_clr),
    .key      (w_key),
    .loaded   (w_key_loaded)
  );

  // The key register owns the shift count, so leaving S_KEY is taken from its
  // loaded flag: the edge that loads the key is the edge that enters S_IDLE.
  assign w_state = (r_state == S_KEY && w_key_loaded) ? S_IDLE : r_state;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_KEY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (w_state)
      S_KEY: begin
        w_state_next = S_KEY;
      end
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (r_settle_cnt == SET_W'(SETTLE - 1)) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_KEY;
    endcase
    // A wipe aborts everything in flight; ready drops so no transfer is implied.
    if (key_clr) begin
      w_state_next = S_KEY;
      w_in_ready   = 1'b0;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_release    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_core_feats     <= '0;
      r_settle_cnt     <= '0;
      r_out_valid      <= 1'b0;
      r_out_decision   <= '0;
      r_out_onehot_err <= 1'b0;
      r_infer_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_core_feats <= in_feats;
        r_settle_cnt <= '0;
      end else if (w_state == S_EVAL) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end

      if (w_capture) begin
        r_out_decision   <= core_decision;
        r_out_onehot_err <= !is_onehot(core_decision);
        r_out_valid      <= 1'b1;
      end else if (w_release || key_clr) begin
        r_out_valid <= 1'b0;
      end

      if (w_release && (r_infer_cnt != {CNT_W{1'b1}})) begin
        r_infer_cnt <= r_infer_cnt + 1'b1;
      end
    end
  end

  assign key_loaded     = w_key_loaded;
  assign in_ready       = w_in_ready;
  assign core_feats     = r_core_feats;
  assign core_key       = w_key_loaded ? w_key : '0;
  assign out_valid      = r_out_valid;
  assign out_decision   = r_out_decision;
  assign out_onehot_err = r_out_onehot_err;
  assign infer_cnt      = r_infer_cnt;

endmodule

// File: tb/tb_dt_infer_ctrl.sv
// Directed self-checking bench for dt_infer_ctrl with hand-computed expectations.
module tb_dt_infer_ctrl;

  localparam int N_FEAT  = 16;
  localparam int FEAT_W  = 10;
  localparam int KEY_W   = 21;
  localparam int N_CLASS = 5;
  localparam int SETTLE  = 2;
  localparam int CNT_W   = 16;
  localparam logic [KEY_W-1:0] KEY_EXP = 21'h16A7C6;

  logic                     CLK;
  logic                     RST;
  logic                     key_shift_en;
  logic                     key_bit;
  logic                     key_clr;
  logic                     key_loaded;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feats;
  logic [N_FEAT*FEAT_W-1:0] core_feats;
  logic [KEY_W-1:0]         core_key;
  logic [N_CLASS-1:0]       core_decision;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_CLASS-1:0]       out_decision;
  logic                     out_onehot_err;
  logic [CNT_W-1:0]         infer_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int key_bits [KEY_W] = '{0,1,1,0,0,0,1,1,1,1,1,0,0,1,0,1,0,1,1,0,1};
  logic [N_FEAT*FEAT_W-1:0] last_feats;

  dt_infer_ctrl #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .KEY_W(KEY_W),
    .N_CLASS(N_CLASS), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .key_shift_en(key_shift_en), .key_bit(key_bit), .key_clr(key_clr),
    .key_loaded(key_loaded),
    .in_valid(in_valid), .in_ready(in_ready), .in_feats(in_feats),
    .core_feats(core_feats), .core_key(core_key), .core_decision(core_decision),
    .out_valid(out_valid), .out_ready(out_ready), .out_decision(out_decision),
    .out_onehot_err(out_onehot_err), .infer_cnt(infer_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [N_FEAT*FEAT_W-1:0] make_feats(input logic [FEAT_W-1:0] f0, input int seed);
    logic [N_FEAT*FEAT_W-1:0] v;
    for (int i = 0; i < N_FEAT; i++) v[i*FEAT_W +: FEAT_W] = FEAT_W'(seed * 37 + i * 61);
    v[FEAT_W-1:0] = f0;
    return v;
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    tick(); tick();
    n_checks++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_key_loaded got %b want 0", key_loaded); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (core_key !== '0) begin n_fail++; $display("FAIL reset_core_key got %h want 0", core_key); end
    n_checks++; if (core_feats !== '0) begin n_fail++; $display("FAIL reset_core_feats got %h want 0", core_feats); end
    n_checks++; if (infer_cnt !== '0) begin n_fail++; $display("FAIL reset_infer_cnt got %0d want 0", infer_cnt); end
    n_checks++; if (out_decision !== '0 || out_onehot_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_dec got %b/%b want 0/0", out_decision, out_onehot_err); end
    RST = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic load_key(input string tag);
    for (int i = 0; i < KEY_W; i++) begin
      key_shift_en = 1'b1;
      key_bit      = key_bits[i][0];
      tick();
      if (i < KEY_W - 1) begin
        n_checks++; if (key_loaded !== 1'b0 || core_key !== '0 || in_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s_partial_key shift %0d got loaded=%b key=%h ready=%b want 0/0/0", tag, i, key_loaded, core_key, in_ready);
        end
      end else begin
        n_checks++; if (key_loaded !== 1'b1) begin n_fail++; $display("FAIL %s_key_loaded got %b want 1", tag, key_loaded); end
        n_checks++; if (core_key !== KEY_EXP) begin n_fail++; $display("FAIL %s_core_key got %h want %h", tag, core_key, KEY_EXP); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready_after_load got %b want 1", tag, in_ready); end
      end
    end
    key_shift_en = 1'b0;
    key_bit      = 1'b0;
    $display("key load (%s) core_key=%h", tag, core_key);
  endtask

  task automatic test_key_load();
    load_key("init");
  endtask

  task automatic test_single_infer();
    core_decision = 5'b01000;
    last_feats    = make_feats(10'd853, 1);
    in_feats      = last_feats;
    in_valid      = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_before got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_after got %b want 0", in_ready); end
    n_checks++; if (core_feats[FEAT_W-1:0] !== 10'd853) begin n_fail++; $display("FAIL single_feat0 got %0d want 853", core_feats[FEAT_W-1:0]); end
    n_checks++; if (core_feats !== last_feats) begin n_fail++; $display("FAIL single_feats got %h want %h", core_feats, last_feats); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_k0 got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_k1 got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_k2 got %b want 1", out_valid); end
    n_checks++; if (out_decision !== 5'b01000) begin n_fail++; $display("FAIL single_decision got %b want 01000", out_decision); end
    n_checks++; if (out_onehot_err !== 1'b0) begin n_fail++; $display("FAIL single_err got %b want 0", out_onehot_err); end
    $display("infer feat0=853 dec=%b err=%b", out_decision, out_onehot_err);
  endtask

  task automatic test_hold();
    out_ready     = 1'b0;
    core_decision = 5'b00010;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_decision !== 5'b01000 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable cyc %0d got v=%b d=%b r=%b want 1/01000/0", i, out_valid, out_decision, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    n_checks++; if (infer_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL hold_cnt got %0d want %0d", infer_cnt, exp_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_drop got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_back got %b want 1", in_ready); end
    $display("result consumed infer_cnt=%0d", infer_cnt);
  endtask

  task automatic test_onehot_err();
    logic [N_CLASS-1:0] decs [3] = '{5'b00000, 5'b10001, 5'b00001};
    logic               errs [3] = '{1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      core_decision = decs[t];
      last_feats    = make_feats(FEAT_W'(100 + t), t + 2);
      in_feats      = last_feats;
      in_valid      = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      n_checks++; if (out_valid !== 1'b1 || out_decision !== decs[t]) begin
        n_fail++; $display("FAIL onehot_dec t%0d got v=%b d=%b want 1/%b", t, out_valid, out_decision, decs[t]);
      end
      n_checks++; if (out_onehot_err !== errs[t]) begin
        n_fail++; $display("FAIL onehot_err t%0d got %b want %b", t, out_onehot_err, errs[t]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_cnt++;
      n_checks++; if (infer_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL onehot_cnt t%0d got %0d want %0d", t, infer_cnt, exp_cnt); end
      $display("infer dec=%b err=%b cnt=%0d", out_decision, out_onehot_err, infer_cnt);
    end
  endtask

  task automatic test_key_clr();
    core_decision = 5'b00100;
    last_feats    = make_feats(10'd511, 9);
    in_feats      = last_feats;
    in_valid      = 1'b1;
    tick();
    in_valid     = 1'b0;
    key_clr      = 1'b1;
    key_shift_en = 1'b1;
    key_bit      = 1'b1;
    tick();
    key_clr      = 1'b0;
    key_shift_en = 1'b0;
    key_bit      = 1'b0;
    n_checks++; if (key_loaded !== 1'b0 || core_key !== '0) begin n_fail++; $display("FAIL clr_key got loaded=%b key=%h want 0/0", key_loaded, core_key); end
    n_checks++; if (core_feats !== last_feats) begin n_fail++; $display("FAIL clr_feats_kept got %h want %h", core_feats, last_feats); end
    n_checks++; if (infer_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL clr_cnt_kept got %0d want %0d", infer_cnt, exp_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL clr_no_result cyc %0d got v=%b r=%b want 0/0", i, out_valid, in_ready);
      end
      tick();
    end
    load_key("reload");
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid_after_reload got %b want 0", out_valid); end
  endtask

  task automatic test_no_accept_and_reset();
    key_clr = 1'b1;
    tick();
    key_clr  = 1'b0;
    in_feats = make_feats(10'd7, 20);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (in_ready !== 1'b0 || core_feats !== last_feats) begin
        n_fail++; $display("FAIL nokey_accept cyc %0d got r=%b feats_changed=%b want 0/0", i, in_ready, core_feats !== last_feats);
      end
    end
    in_valid = 1'b0;
    load_key("pre_rst");
    core_decision = 5'b00001;
    in_valid      = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_setup_hold got %b want 1", out_valid); end
    RST = 1'b0;
    tick();
    RST = 1'b1;
    n_checks++; if (key_loaded !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_ctrl got loaded=%b ready=%b valid=%b want 0/0/0", key_loaded, in_ready, out_valid);
    end
    n_checks++; if (core_feats !== '0 || core_key !== '0) begin n_fail++; $display("FAIL rst_core got feats=%h key=%h want 0/0", core_feats, core_key); end
    n_checks++; if (out_decision !== '0 || out_onehot_err !== 1'b0) begin n_fail++; $display("FAIL rst_out got %b/%b want 0/0", out_decision, out_onehot_err); end
    n_checks++; if (infer_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", infer_cnt); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0 || core_feats !== '0) begin n_fail++; $display("FAIL rst_in_key_state got r=%b feats=%h want 0/0", in_ready, core_feats); end
    $display("reset in hold: outputs cleared");
  endtask

  initial begin
    RST           = 1'b0;
    key_shift_en  = 1'b0;
    key_bit       = 1'b0;
    key_clr       = 1'b0;
    in_valid      = 1'b0;
    in_feats      = '0;
    core_decision = '0;
    out_ready     = 1'b0;
    last_feats    = '0;
    test_reset();
    test_key_load();
    test_single_infer();
    test_hold();
    test_onehot_err();
    test_key_clr();
    test_no_accept_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dt_infer_ctrl.md
Name: dt_infer_ctrl

Overview:
Inference sequencer that wraps the key-locked decision-tree classifier core, which is purely combinational. It loads the 21-bit unlock key serially into a register, accepts one feature vector at a time through a valid/ready handshake, and holds the features stable for SETTLE cycles. It then captures the class decision into a valid/ready output stage and flags any decision that is not one-hot. It sits between the sensor front-end and the downstream consumer of the class result.

Parameters:
N_FEAT, 16, number of feature inputs to the core
FEAT_W, 10, width of each feature
KEY_W, 21, key length in bits
N_CLASS, 5, width of the core decision bus
SETTLE, 2, cycles the core is given to settle before capture (must be >= 1)
CNT_W, 16, width of the inference counter

Ports:
CLK  in  1  clock, all logic rising-edge
RST  in  1  synchronous, active-low reset
key_shift_en  in  1  shift key_bit into the key register this cycle
key_bit  in  1  serial key data, LSB first
key_clr  in  1  synchronous key wipe and abort
key_loaded  out  1  full key present
in_valid  in  1  feature vector valid
in_ready  out  1  controller can accept a vector
in_feats  in  N_FEAT*FEAT_W  packed features, feature 0 in the LSBs
core_feats  out  N_FEAT*FEAT_W  registered features driven to the core
core_key  out  KEY_W  key driven to the core
core_decision  in  N_CLASS  core output
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_decision  out  N_CLASS  captured decision
out_onehot_err  out  1  captured decision is not one-hot
infer_cnt  out  CNT_W  completed inferences, saturating

Behaviour:
- States: S_KEY, S_IDLE, S_EVAL, S_HOLD.
- Reset (RST=0 at an edge) has top priority:
  - state goes to S_KEY;
  - key register, bit counter, settle counter and infer_cnt clear to 0;
  - every output is 0, including core_feats and core_key.
- Key register and core_key:
  - core_key = key register when key_loaded=1, otherwise all zeros, so a partial key is never presented to the core.
- S_KEY:
  - in_ready=0.
  - On key_shift_en=1: key_reg <= {key_bit, key_reg[KEY_W-1:1]} and bit_cnt increments. After KEY_W shifts, the first bit shifted in sits at KEY[0].
  - The shift that brings bit_cnt to KEY_W moves the FSM to S_IDLE; key_loaded goes to 1 at that same edge.
  - key_shift_en in any other state is ignored.
- S_IDLE:
  - in_ready=1.
  - On in_valid & in_ready, in_feats is registered into core_feats, the settle counter resets to 0, and the FSM moves to S_EVAL.
  - core_feats holds its last value whenever no transfer occurs.
- S_EVAL:
  - in_ready=0; the settle counter increments each cycle.
  - In the cycle where the counter equals SETTLE-1, at the edge that ends that cycle:
    - out_decision <= core_decision;
    - out_onehot_err <= (popcount(core_decision) != 1);
    - out_valid <= 1;
    - the FSM moves to S_HOLD.
  - Latency: a vector accepted at edge k gives out_valid=1 from edge k+SETTLE.
- S_HOLD:
  - out_valid, out_decision and out_onehot_err stay stable until out_ready=1.
  - On out_valid & out_ready: out_valid <= 0, infer_cnt increments (it holds at all-ones), and the FSM moves to S_IDLE.
  - in_ready is not asserted in the handshake cycle. There is no bypass, so throughput is one vector per SETTLE+2 cycles at best.
- key_clr=1 (any state, lower priority than RST):
  - key_reg, bit_cnt and key_loaded clear; out_valid <= 0; the FSM moves to S_KEY.
  - Any in-flight or held result is discarded.
  - infer_cnt, out_decision and core_feats retain their values.
  - key_clr beats key_shift_en in the same cycle (that shift is dropped).
- in_valid asserted while in S_KEY, S_EVAL or S_HOLD is not accepted (in_ready=0). The source must hold the vector until it is accepted.
- out_onehot_err covers both cases: zero bits set and two or more bits set.

Decomposition:
- Package dt_ctrl_pkg holds:
  - the state enum;
  - the default widths (N_FEAT, FEAT_W, KEY_W, N_CLASS);
  - a function is_onehot(N_CLASS-bit) returning 1 for exactly one bit set.
- Sub-module dt_key_shreg holds the serial key register, bit counter, key_loaded and the clear logic. Its interface is CLK, RST, shift_en, bit_in, clr, key, loaded.
- dt_infer_ctrl instantiates dt_key_shreg plus the FSM and the datapath registers.

Test Plan:
1. Reset, then 21 shifts of bits 0,1,1,0,0,0,1,1,1,1,1,0,0,1,0,1,0,1,1,0,1 (in that order) -> key_loaded=1 at the 21st shift edge, core_key=21'h16A7C6, core_key=0 at every earlier edge.
2. SETTLE=2, key loaded, core_decision tied to 5'b01000, in_valid pulse with feature 0=853 -> in_ready drops after accept; out_valid=1 exactly 2 edges after accept; out_decision=5'b01000; out_onehot_err=0; core_feats[9:0]=853.
3. out_ready held low 10 cycles in S_HOLD -> out_valid and out_decision stable, in_ready=0; then out_ready=1 for one cycle -> infer_cnt=1, out_valid=0, in_ready=1 on the following cycle.
4. core_decision=5'b00000, then 5'b10001, on two inferences -> out_onehot_err=1 both times; 5'b00001 -> out_onehot_err=0.
5. key_clr asserted during S_EVAL, together with key_shift_en=1 -> out_valid never rises, key_loaded=0, core_key=0, in_ready=0 until 21 new shifts, infer_cnt unchanged.
6. in_valid=1 held before the key is loaded -> no accept, in_ready=0. Then RST=0 for one edge while in S_HOLD -> all outputs 0, infer_cnt=0, FSM in S_KEY.
